toggle_cover_detector: RTL and testbench

Per-bit toggle detector that feeds the toggle coverage reporting stage. Samples a `WIDTH`-bit probed signal each cycle, detects 0→1 and 1→0 transitions per bit, and emits a registered `2*WIDTH`-bit `valid` vector that connects directly to the coverage stage's `valid` input. It also keeps a running count of distinct covered toggle points so that coverage closure can be observed in-design.

---
 rtl/toggle_cover_pkg.sv | 21 ++
 rtl/toggle_popcount.sv | 33 +++
 rtl/toggle_cover_detector.sv | 101 ++++++++++
 tb/tb_toggle_cover_detector.sv | 163 ++++++++++++++++
 4 files changed

// File: rtl/toggle_cover_pkg.sv
// Shared definitions for the toggle coverage detectors: vector offsets,
// width helpers and the priming state encoding.
package toggle_cover_pkg;

  localparam int unsigned RISE_OFS = 0;
  localparam int unsigned FALL_OFS = 1;

  typedef enum logic {
    UNPRIMED = 1'b0,
    PRIMED   = 1'b1
  } prime_state_e;

  function automatic int unsigned cover_width(input int unsigned w);
    return 2 * w;
  endfunction

  function automatic int unsigned count_width(input int unsigned w);
    return $clog2(2 * w + 1);
  endfunction

endpackage

// File: rtl/toggle_popcount.sv
// Combinational population count built as a recursive binary adder tree.
// Every node carries the full CW-bit result width, so no node can overflow.
module toggle_popcount #(
  parameter int unsigned N  = 8,
  parameter int unsigned CW = 4
) (
  input  logic [N-1:0]  bits_i,
  output logic [CW-1:0] count_o
);

  if (N == 1) begin : g_leaf
    assign count_o = CW'(bits_i);
  end else begin : g_node
    localparam int unsigned NLO = N / 2;
    localparam int unsigned NHI = N - NLO;

    logic [CW-1:0] lo_cnt;
    logic [CW-1:0] hi_cnt;

    toggle_popcount #(.N(NLO), .CW(CW)) u_lo (
      .bits_i  (bits_i[NLO-1:0]),
      .count_o (lo_cnt)
    );

    toggle_popcount #(.N(NHI), .CW(CW)) u_hi (
      .bits_i  (bits_i[N-1:NLO]),
      .count_o (hi_cnt)
    );

    assign count_o = lo_cnt + hi_cnt;
  end

endmodule

// File: rtl/toggle_cover_detector.sv
// Per-bit rise/fall toggle detector with a running distinct-point count.
// Build option TOGGLE_DEDUP_EN: report each toggle point at most once per clear.
module toggle_cover_detector
  import toggle_cover_pkg::*;
#(
  parameter int unsigned WIDTH = 28
) (
  input  logic                                clock,
  input  logic                                reset,
  input  logic                                en,
  input  logic                                clear,
  input  logic [WIDTH-1:0]                    sig,
  output logic [cover_width(WIDTH)-1:0]       valid,
  output logic [count_width(WIDTH)-1:0]       hit_count,
  output logic                                all_covered
);

  localparam int unsigned CW = cover_width(WIDTH);
  localparam int unsigned KW = count_width(WIDTH);

  prime_state_e  primed_q, primed_d;
  logic [WIDTH-1:0] prev_q, prev_d;
  logic [CW-1:0] seen_q, seen_d;
  logic [CW-1:0] valid_q, valid_d;
  logic [KW-1:0] hit_count_q, hit_count_d;

  logic [CW-1:0] raw;
  logic [CW-1:0] new_hits;
  logic [KW-1:0] new_count;

  // State register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      primed_q <= UNPRIMED;
    end else begin
      primed_q <= primed_d;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      prev_q      <= '0;
      seen_q      <= '0;
      valid_q     <= '0;
      hit_count_q <= '0;
    end else begin
      prev_q      <= prev_d;
      seen_q      <= seen_d;
      valid_q     <= valid_d;
      hit_count_q <= hit_count_d;
    end
  end

  // Interleaved rise/fall hits; nothing is reported until a baseline is captured
  always_comb begin
    raw = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      raw[2*i+RISE_OFS] = (primed_q == PRIMED) &  sig[i] & ~prev_q[i];
      raw[2*i+FALL_OFS] = (primed_q == PRIMED) & ~sig[i] &  prev_q[i];
    end
  end

  assign new_hits = raw & ~seen_q;

  toggle_popcount #(.N(CW), .CW(KW)) u_popcount (
    .bits_i  (new_hits),
    .count_o (new_count)
  );

  // Next-state logic; clear wins over any toggle sampled on the same edge
  always_comb begin
    primed_d    = primed_q;
    prev_d      = prev_q;
    seen_d      = seen_q;
    hit_count_d = hit_count_q;
    valid_d     = '0;
    if (clear) begin
      primed_d    = UNPRIMED;
      seen_d      = '0;
      hit_count_d = '0;
    end else if (en) begin
      primed_d    = PRIMED;
      prev_d      = sig;
      seen_d      = seen_q | raw;
      hit_count_d = hit_count_q + new_count;
`ifdef TOGGLE_DEDUP_EN
      valid_d     = new_hits;
`else
      valid_d     = raw;
`endif
    end
  end

  // Outputs
  always_comb begin
    valid       = valid_q;
    hit_count   = hit_count_q;
    all_covered = (hit_count_q == KW'(CW));
  end

endmodule

// File: tb/tb_toggle_cover_detector.sv
// Directed table-driven bench for toggle_cover_detector at WIDTH=4, plus
// hand-written reset sequences; expectations follow TOGGLE_DEDUP_EN.
module tb_toggle_cover_detector;

  localparam int unsigned W  = 4;
  localparam int unsigned CW = 2 * W;
  localparam int unsigned KW = $clog2(2 * W + 1);

`ifdef TOGGLE_DEDUP_EN
  localparam bit DD = 1'b1;
`else
  localparam bit DD = 1'b0;
`endif

  typedef struct {
    logic          en;
    logic          clr;
    logic [W-1:0]  sig;
    logic [CW-1:0] v;
    logic [KW-1:0] c;
    logic          a;
  } vec_t;

  logic          clock;
  logic          reset;
  logic          en;
  logic          clear;
  logic [W-1:0]  sig;
  logic [CW-1:0] valid;
  logic [KW-1:0] hit_count;
  logic          all_covered;

  int total;
  int bad;

  vec_t tbl[64];
  int   ntbl;

  toggle_cover_detector #(.WIDTH(W)) dut (
    .clock       (clock),
    .reset       (reset),
    .en          (en),
    .clear       (clear),
    .sig         (sig),
    .valid       (valid),
    .hit_count   (hit_count),
    .all_covered (all_covered)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic add(input logic e, input logic c, input logic [W-1:0] s,
                     input logic [CW-1:0] ev, input logic [KW-1:0] ec, input logic ea);
    tbl[ntbl].en  = e;
    tbl[ntbl].clr = c;
    tbl[ntbl].sig = s;
    tbl[ntbl].v   = ev;
    tbl[ntbl].c   = ec;
    tbl[ntbl].a   = ea;
    ntbl++;
  endtask

  task automatic check(input string name, input logic [CW-1:0] ev,
                       input logic [KW-1:0] ec, input logic ea);
    total++;
    if (valid !== ev) begin
      bad++;
      $display("FAIL %s valid: got %h want %h", name, valid, ev);
    end
    total++;
    if (hit_count !== ec) begin
      bad++;
      $display("FAIL %s hit_count: got %0d want %0d", name, hit_count, ec);
    end
    total++;
    if (all_covered !== ea) begin
      bad++;
      $display("FAIL %s all_covered: got %0b want %0b", name, all_covered, ea);
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    ntbl  = 0;

    // en, clr, sig, valid, count, all
    add(1, 0, 4'h5, 8'h00, 0, 0);   // priming edge
    add(1, 0, 4'h5, 8'h00, 0, 0);
    add(1, 1, 4'h0, 8'h00, 0, 0);   // clear
    add(1, 0, 4'h0, 8'h00, 0, 0);   // re-prime at 0
    add(1, 0, 4'h1, 8'h01, 1, 0);   // rise bit0
    add(1, 0, 4'h0, 8'h02, 2, 0);   // fall bit0
    for (int k = 0; k < 3; k++) begin
      add(1, 0, 4'h1, DD ? 8'h00 : 8'h01, 2, 0);
      add(1, 0, 4'h0, DD ? 8'h00 : 8'h02, 2, 0);
    end
    add(1, 1, 4'h0, 8'h00, 0, 0);   // clear
    add(1, 0, 4'h0, 8'h00, 0, 0);   // re-prime
    add(1, 0, 4'hF, 8'h55, 4, 0);
    add(1, 0, 4'h0, 8'hAA, 8, 1);
    add(1, 0, 4'hF, DD ? 8'h00 : 8'h55, 8, 1);  // count saturated
    add(1, 0, 4'hB, DD ? 8'h00 : 8'h20, 8, 1);
    add(1, 1, 4'hF, 8'h00, 0, 0);   // clear collides with bit2 rise
    add(1, 0, 4'hF, 8'h00, 0, 0);   // re-prime, no hit
    add(1, 0, 4'hF, 8'h00, 0, 0);
    add(0, 0, 4'h0, 8'h00, 0, 0);   // gated toggle away
    add(0, 0, 4'hF, 8'h00, 0, 0);   // and back
    add(1, 0, 4'hF, 8'h00, 0, 0);   // nothing seen
    add(0, 0, 4'hE, 8'h00, 0, 0);   // gated change that persists
    add(1, 0, 4'hE, 8'h02, 1, 0);   // detected when en returns
    add(1, 0, 4'hC, 8'h08, 2, 0);
    add(1, 0, 4'hF, 8'h05, 4, 0);
    add(1, 0, 4'h7, 8'h80, 5, 0);

    // Reset held for three cycles with sig = 5
    reset = 1'b0;
    en    = 1'b1;
    clear = 1'b0;
    sig   = 4'h5;
    for (int k = 0; k < 3; k++) begin
      @(negedge clock);
      check("in_reset", 8'h00, 0, 0);
    end
    reset = 1'b1;

    for (int i = 0; i < ntbl; i++) begin
      en    = tbl[i].en;
      clear = tbl[i].clr;
      sig   = tbl[i].sig;
      @(posedge clock);
      @(negedge clock);
      check($sformatf("row%0d", i), tbl[i].v, tbl[i].c, tbl[i].a);
    end

    // Asynchronous reset between edges with hit_count = 5 and valid pending
    #1;
    reset = 1'b0;
    #1;
    check("async_reset", 8'h00, 0, 0);
    @(negedge clock);
    check("async_reset_hold", 8'h00, 0, 0);
    reset = 1'b1;
    en    = 1'b1;
    sig   = 4'h7;
    @(posedge clock);
    @(negedge clock);
    check("post_reset_prime", 8'h00, 0, 0);
    sig = 4'h6;
    @(posedge clock);
    @(negedge clock);
    check("post_reset_fall", 8'h02, 1, 0);
    en = 1'b0;
    @(posedge clock);
    @(negedge clock);
    check("en_low_drops_valid", 8'h00, 1, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
